// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared encodings for the msrv32 fetch controller
package msrv32_pkg;

  // Source of the next PC as seen on pc_src_out
  typedef enum logic [1:0] {
    PC_SRC_BOOT = 2'b00,
    PC_SRC_EPC  = 2'b01,
    PC_SRC_TRAP = 2'b10,
    PC_SRC_SEQ  = 2'b11
  } pc_src_e;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  // Redirect priority; numerically larger wins
  typedef enum logic [1:0] {
    PRIO_NONE   = 2'd0,
    PRIO_BRANCH = 2'd1,
    PRIO_MRET   = 2'd2,
    PRIO_TRAP   = 2'd3
  } redirect_prio_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [15:0] REDIRECT_CNT_MAX = 16'hFFFF;

  // Branches share the sequential encoding; only trap and mret are distinct
  function automatic pc_src_e prio_to_src(input redirect_prio_e prio);
    case (prio)
      PRIO_TRAP: return PC_SRC_TRAP;
      PRIO_MRET: return PC_SRC_EPC;
      default:   return PC_SRC_SEQ;
    endcase
  endfunction

  // Trap vectors and return addresses are always word aligned
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/msrv32_fetch_ctrl_if.sv
// rtl/msrv32_fetch_ctrl_if.sv - instruction fetch bus handshake bundle
interface msrv32_fetch_ctrl_if;
  logic        ahb_ready_in;
  logic [31:0] iaddr_out;
  logic        fetch_valid_out;

  // Fetch controller side: presents the address, sees the bus accept it
  modport master (
    input  ahb_ready_in,
    output iaddr_out,
    output fetch_valid_out
  );

  // Instruction bus side
  modport slave (
    output ahb_ready_in,
    input  iaddr_out,
    input  fetch_valid_out
  );
endinterface

// File: rtl/msrv32_redirect_latch.sv
// rtl/msrv32_redirect_latch.sv - pending redirect held while the bus stalls
module msrv32_redirect_latch
  import msrv32_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_en_i,
  input  logic           clear_i,
  input  redirect_prio_e req_prio_i,
  input  logic [31:0]    req_target_i,
  output redirect_prio_e pend_prio_o,
  output logic [31:0]    pend_target_o,
  output logic           req_wins_o
);

  redirect_prio_e prio_q, prio_d;
  logic [31:0]    target_q, target_d;

  // A live request displaces the pending one on equal or higher priority
  assign req_wins_o = (req_prio_i != PRIO_NONE) && (req_prio_i >= prio_q);

  // Next pending entry: clear on consumption, otherwise priority-compare load
  always_comb begin
    prio_d   = prio_q;
    target_d = target_q;
    if (clear_i) begin
      prio_d = PRIO_NONE;
    end else if (load_en_i && req_wins_o) begin
      prio_d   = req_prio_i;
      target_d = req_target_i;
    end
  end

  // Pending register; reset discards any held redirect immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q   <= PRIO_NONE;
      target_q <= 32'h0;
    end else begin
      prio_q   <= prio_d;
      target_q <= target_d;
    end
  end

  assign pend_prio_o   = prio_q;
  assign pend_target_o = target_q;

endmodule

// File: rtl/msrv32_fetch_ctrl.sv
// rtl/msrv32_fetch_ctrl.sv - program counter sequencing and redirect arbitration
module msrv32_fetch_ctrl
  import msrv32_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  msrv32_fetch_ctrl_if.master        ibus,
  input  logic                       branch_taken_in,
  input  logic [31:0]                branch_target_in,
  input  logic                       trap_taken_in,
  input  logic [31:0]                trap_address_in,
  input  logic                       mret_in,
  input  logic [31:0]                epc_in,
  output logic [1:0]                 pc_src_out,
  output logic [31:0]                pc_out,
  output logic                       misaligned_instr_out,
  output logic [15:0]                redirect_cnt_out
);

  fetch_state_e   state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           mis_q, mis_d;

  redirect_prio_e live_prio, pend_prio, eff_prio;
  logic [31:0]    live_target, pend_target, eff_target;
  logic           live_wins;
  logic           in_fetch, advance, stall;
  logic           mis_hit, applied;

  // Resolve this cycle's requests: trap > mret > branch
  always_comb begin
    live_prio   = PRIO_NONE;
    live_target = 32'h0;
    if (trap_taken_in) begin
      live_prio   = PRIO_TRAP;
      live_target = word_align(trap_address_in);
    end else if (mret_in) begin
      live_prio   = PRIO_MRET;
      live_target = word_align(epc_in);
    end else if (branch_taken_in) begin
      live_prio   = PRIO_BRANCH;
      live_target = branch_target_in;
    end
  end

  assign in_fetch = (state_q != ST_BOOT);
  assign advance  = in_fetch && ibus.ahb_ready_in;
  assign stall    = in_fetch && !ibus.ahb_ready_in;

  msrv32_redirect_latch u_redirect_latch (
    .clk_i         (clk_in),
    .rst_i         (rst_in),
    .load_en_i     (stall),
    .clear_i       (advance),
    .req_prio_i    (live_prio),
    .req_target_i  (live_target),
    .pend_prio_o   (pend_prio),
    .pend_target_o (pend_target),
    .req_wins_o    (live_wins)
  );

  // Pending is always empty in RUN, so this reduces to the live request there
  assign eff_prio   = live_wins ? live_prio : pend_prio;
  assign eff_target = live_wins ? live_target : pend_target;
  assign mis_hit    = (eff_prio == PRIO_BRANCH) && eff_target[1];
  assign applied    = (eff_prio != PRIO_NONE) && !mis_hit;

  // FSM state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  // FSM next state: every accepted fetch returns to RUN, every stall parks in WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: if (ibus.ahb_ready_in) state_d = ST_RUN;
      ST_RUN:  if (!ibus.ahb_ready_in) state_d = ST_WAIT;
      ST_WAIT: if (ibus.ahb_ready_in) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // FSM outputs: next PC, redirect counter, misalignment pulse, PC source
  always_comb begin
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    mis_d      = 1'b0;
    pc_src_out = PC_SRC_BOOT;
    case (state_q)
      ST_BOOT: begin
        pc_src_out = PC_SRC_BOOT;
        if (ibus.ahb_ready_in) pc_d = pc_q + PC_STEP;
      end
      ST_RUN, ST_WAIT: begin
        pc_src_out = prio_to_src(eff_prio);
        if (advance) begin
          if (eff_prio == PRIO_NONE) begin
            pc_d = pc_q + PC_STEP;
          end else if (mis_hit) begin
            mis_d = 1'b1;
          end else begin
            pc_d = eff_target;
          end
          if (applied && (cnt_q != REDIRECT_CNT_MAX)) cnt_d = cnt_q + 16'd1;
        end
      end
      default: pc_src_out = PC_SRC_BOOT;
    endcase
  end

  // PC, counter and pulse registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc_q  <= BOOT_ADDRESS;
      cnt_q <= 16'h0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      mis_q <= mis_d;
    end
  end

  assign pc_out               = pc_q;
  assign ibus.iaddr_out       = pc_q;
  assign ibus.fetch_valid_out = !rst_in;
  assign misaligned_instr_out = mis_q;
  assign redirect_cnt_out     = cnt_q;

endmodule

// File: tb/tb_msrv32_fetch_ctrl.sv
// tb/tb_msrv32_fetch_ctrl.sv - scoreboard bench for the fetch controller
module tb_msrv32_fetch_ctrl;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_BR   = 2'd1;
  localparam logic [1:0] K_MRET = 2'd2;
  localparam logic [1:0] K_TRAP = 2'd3;

  localparam logic [1:0] S_BOOT = 2'b00;
  localparam logic [1:0] S_EPC  = 2'b01;
  localparam logic [1:0] S_TRAP = 2'b10;
  localparam logic [1:0] S_SEQ  = 2'b11;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] cnt;
    logic        mis;
  } exp_t;

  logic        clk_in;
  logic        rst_in;
  logic        branch_taken_in;
  logic [31:0] branch_target_in;
  logic        trap_taken_in;
  logic [31:0] trap_address_in;
  logic        mret_in;
  logic [31:0] epc_in;
  logic [1:0]  pc_src_out;
  logic [31:0] pc_out;
  logic        misaligned_instr_out;
  logic [15:0] redirect_cnt_out;

  int   n_total;
  int   n_bad;
  exp_t sb[$];

  msrv32_fetch_ctrl_if ibus ();

  msrv32_fetch_ctrl #(.BOOT_ADDRESS(32'h0000_0000)) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .ibus                 (ibus),
    .branch_taken_in      (branch_taken_in),
    .branch_target_in     (branch_target_in),
    .trap_taken_in        (trap_taken_in),
    .trap_address_in      (trap_address_in),
    .mret_in              (mret_in),
    .epc_in               (epc_in),
    .pc_src_out           (pc_src_out),
    .pc_out               (pc_out),
    .misaligned_instr_out (misaligned_instr_out),
    .redirect_cnt_out     (redirect_cnt_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic [1:0] kind, input logic [31:0] tgt);
    ibus.ahb_ready_in = rdy;
    branch_taken_in   = (kind == K_BR);
    mret_in           = (kind == K_MRET);
    trap_taken_in     = (kind == K_TRAP);
    branch_target_in  = (kind == K_BR)   ? tgt : 32'h0;
    epc_in            = (kind == K_MRET) ? tgt : 32'h0;
    trap_address_in   = (kind == K_TRAP) ? tgt : 32'h0;
  endtask

  // One clock: drive, check source selection, push expectation, pop after the edge
  task automatic step(input logic rdy, input logic [1:0] kind, input logic [31:0] tgt,
                      input logic [1:0] exp_src, input logic [31:0] exp_pc,
                      input logic [15:0] exp_cnt, input logic exp_mis);
    exp_t e;
    @(negedge clk_in);
    drive(rdy, kind, tgt);
    #1;
    chk("pc_src", {30'h0, pc_src_out}, {30'h0, exp_src});
    e.pc  = exp_pc;
    e.cnt = exp_cnt;
    e.mis = exp_mis;
    sb.push_back(e);
    @(posedge clk_in);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("pc_out", pc_out, e.pc);
      chk("iaddr_out", ibus.iaddr_out, e.pc);
      chk("redirect_cnt", {16'h0, redirect_cnt_out}, {16'h0, e.cnt});
      chk("misaligned", {31'h0, misaligned_instr_out}, {31'h0, e.mis});
      chk("fetch_valid", {31'h0, ibus.fetch_valid_out}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] pc;
    n_total = 0;
    n_bad   = 0;
    rst_in  = 1'b1;
    drive(1'b0, K_NONE, 32'h0);
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_iaddr", ibus.iaddr_out, 32'h0);
    chk("rst_src", {30'h0, pc_src_out}, {30'h0, S_BOOT});
    chk("rst_valid", {31'h0, ibus.fetch_valid_out}, 32'd0);
    chk("rst_mis", {31'h0, misaligned_instr_out}, 32'd0);
    chk("rst_cnt", {16'h0, redirect_cnt_out}, 32'd0);

    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk("boot_iaddr", ibus.iaddr_out, 32'h0);
    chk("boot_valid", {31'h0, ibus.fetch_valid_out}, 32'd1);

    // Boot then sequential fetch up to 0x100
    step(1'b1, K_NONE, 32'h0, S_BOOT, 32'h4, 16'd0, 1'b0);
    step(1'b1, K_NONE, 32'h0, S_SEQ,  32'h8, 16'd0, 1'b0);
    pc = 32'h8;
    while (pc != 32'h100) begin
      pc = pc + 32'd4;
      step(1'b1, K_NONE, 32'h0, S_SEQ, pc, 16'd0, 1'b0);
    end

    // Branch redirect with one-cycle latency
    step(1'b1, K_BR, 32'h200, S_SEQ, 32'h200, 16'd1, 1'b0);

    // Stalled branch overridden by a trap, applied on ready
    step(1'b0, K_BR,   32'h300,      S_SEQ,  32'h200,      16'd1, 1'b0);
    step(1'b0, K_TRAP, 32'h12345678, S_TRAP, 32'h200,      16'd1, 1'b0);
    step(1'b1, K_NONE, 32'h0,        S_TRAP, 32'h12345678, 16'd2, 1'b0);

    // mret with low bits forced to zero
    step(1'b1, K_MRET, 32'h803, S_EPC, 32'h800, 16'd3, 1'b0);

    // Misaligned branch: pulse, PC held, counter unchanged
    step(1'b1, K_BR,   32'h402, S_SEQ, 32'h800, 16'd3, 1'b1);
    step(1'b1, K_NONE, 32'h0,   S_SEQ, 32'h804, 16'd3, 1'b0);

    // Trap vector alignment
    step(1'b1, K_TRAP, 32'h1003, S_TRAP, 32'h1000, 16'd4, 1'b0);

    // Lower-priority request does not displace pending mret
    step(1'b0, K_MRET, 32'h2000, S_EPC, 32'h1000, 16'd4, 1'b0);
    step(1'b0, K_BR,   32'h3000, S_EPC, 32'h1000, 16'd4, 1'b0);
    step(1'b1, K_NONE, 32'h0,    S_EPC, 32'h2000, 16'd5, 1'b0);

    // Same-cycle higher request beats pending branch
    step(1'b0, K_BR,   32'h4000, S_SEQ,  32'h2000, 16'd5, 1'b0);
    step(1'b1, K_TRAP, 32'h5000, S_TRAP, 32'h5000, 16'd6, 1'b0);

    // Stall with nothing pending resumes sequentially
    step(1'b0, K_NONE, 32'h0, S_SEQ, 32'h5000, 16'd6, 1'b0);
    step(1'b1, K_NONE, 32'h0, S_SEQ, 32'h5004, 16'd6, 1'b0);

    // Sequential wrap at the top of the address space
    step(1'b1, K_TRAP, 32'hFFFF_FFFC, S_TRAP, 32'hFFFF_FFFC, 16'd7, 1'b0);
    step(1'b1, K_NONE, 32'h0,         S_SEQ,  32'h0000_0000, 16'd7, 1'b0);

    // Reset in the middle of a stall discards the pending trap
    step(1'b1, K_BR,   32'h700,  S_SEQ,  32'h700, 16'd8, 1'b0);
    step(1'b0, K_TRAP, 32'h6000, S_TRAP, 32'h700, 16'd8, 1'b0);
    #2;
    rst_in = 1'b1;
    #1;
    chk("midwait_rst_pc", pc_out, 32'h0);
    chk("midwait_rst_cnt", {16'h0, redirect_cnt_out}, 32'd0);
    chk("midwait_rst_src", {30'h0, pc_src_out}, {30'h0, S_BOOT});
    chk("midwait_rst_valid", {31'h0, ibus.fetch_valid_out}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    step(1'b1, K_NONE, 32'h0, S_BOOT, 32'h4, 16'd0, 1'b0);
    step(1'b1, K_NONE, 32'h0, S_SEQ,  32'h8, 16'd0, 1'b0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/msrv32_fetch_ctrl.md
MSRV32_FETCH_CTRL -- requirements
Module: msrv32_fetch_ctrl

Interface
REQ-001 SHALL have parameter BOOT_ADDRESS, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have ports clk_in (input, 1, sole clock) and rst_in (input, 1, reset); one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port ahb_ready_in (input, 1): the instruction bus accepts the current fetch address this cycle.
REQ-004 SHALL have ports branch_taken_in (input, 1) and branch_target_in (input, 32): branch/jump redirect request and its target.
REQ-005 SHALL have ports trap_taken_in (input, 1) and trap_address_in (input, 32): trap entry request and vector.
REQ-006 SHALL have ports mret_in (input, 1) and epc_in (input, 32): trap return request and return address.
REQ-007 SHALL have port pc_src_out (output, 2): selected source; 00 boot, 01 epc, 10 trap, 11 sequential/branch.
REQ-008 SHALL have ports pc_out (output, 32; registered current PC) and iaddr_out (output, 32; fetch address, equal to pc_out).
REQ-009 SHALL have ports fetch_valid_out (output, 1; iaddr_out valid) and misaligned_instr_out (output, 1; one-cycle pulse).
REQ-010 SHALL have port redirect_cnt_out (output, 16): count of applied non-sequential redirects.

Function
REQ-011 SHALL implement FSM states BOOT, RUN, WAIT.
REQ-012 BOOT: fetch_valid_out=1, iaddr_out=BOOT_ADDRESS, pc_src_out=00; ahb_ready_in=1 -> RUN with pc_out <= BOOT_ADDRESS+4; else stay in BOOT.
REQ-013 RUN, ahb_ready_in=1: pc_out <= selected next PC in the edge after the request (1-cycle latency); priority trap > mret > branch > pc_out+4.
REQ-014 RUN, ahb_ready_in=0: pc_out held; any request is latched into the pending register; state -> WAIT.
REQ-015 WAIT: further requests replace the pending one only if equal or higher priority; pc_out held; fetch_valid_out stays 1.
REQ-016 WAIT, ahb_ready_in=1: pc_out <= pending target, else pc_out+4 if none pending; pending cleared; -> RUN; a same-cycle new request of higher or equal priority wins over pending.
REQ-017 Trap and epc targets SHALL have bits [1:0] forced to 00.
REQ-018 Branch target with bit 1 set: misaligned_instr_out pulses 1 cycle, redirect dropped, pc_out held for that cycle.
REQ-019 Sequential increment wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-020 redirect_cnt_out increments by 1 per applied trap/mret/branch redirect and saturates at 16'hFFFF.
REQ-021 pc_src_out reflects the source used for the next pc_out update (11 when sequential).

Reset
REQ-022 While rst_in=1: state=BOOT, pc_out=iaddr_out=BOOT_ADDRESS, pc_src_out=00, fetch_valid_out=0, misaligned_instr_out=0, redirect_cnt_out=0, pending cleared.
REQ-023 Reset asserted mid-WAIT SHALL discard the pending redirect immediately (asynchronous).

Structure
REQ-024 SHALL take pc_src encodings, FSM state encoding and the priority ordering from shared package msrv32_pkg.
REQ-025 SHALL contain one sub-module, msrv32_redirect_latch: pending target plus priority register with a priority-compare update.

Verification
REQ-026 Reset release, ahb_ready_in=1 -> iaddr_out 0x0, then 0x4, 0x8 on consecutive cycles; pc_src_out=11 after BOOT.
REQ-027 RUN at pc 0x100, branch_taken_in to 0x200 -> pc_out=0x200 next cycle, redirect_cnt_out=1.
REQ-028 ahb_ready_in=0 and branch to 0x300, then trap to 0x12345678 while stalled, then ready -> pc_out=0x12345678.
REQ-029 Branch target 0x402 -> misaligned_instr_out one-cycle pulse, pc_out unchanged, counter unchanged.
REQ-030 pc_out=0xFFFF_FFFC, no request -> pc_out=0x0; rst_in pulse mid-WAIT -> pc_out=BOOT_ADDRESS, pending lost.
